// File: rtl/imem_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
interface imem_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        ready;

    modport master (output req, output addr, input rdata, input ready);
    modport slave  (input req, input addr, output rdata, output ready);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ready handshake with
// timeout, latches the instruction for decode and commits the next PC at WB.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         if_en,
    input  logic         wb_en,
    input  logic [1:0]   pc_src,
    input  logic [31:0]  branch_target,
    input  logic [31:0]  jump_target,
    imem_if.master       imem,
    output logic [31:0]  pc,
    output logic [31:0]  pc_plus4,
    output logic [31:0]  instr,
    output logic         instr_valid,
    output logic         fetch_busy,
    output logic         fetch_err,
    output logic         overrun
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cnt;
    logic [31:0] pc_sel;
    logic [31:0] pending;
    logic        pending_vld;
    logic        start;
    logic        hit;
    logic        tmo;
    logic        in_req;

    assign in_req     = (state == REQ);
    assign pc_plus4   = pc + 32'd4;
    assign imem.req   = in_req;
    assign imem.addr  = {pc[31:2], 2'b00};
    assign fetch_busy = in_req;

    // Next-PC source mux; source 3 holds the current PC.
    always_comb begin
        pc_sel = pc;
        case (pc_src)
            2'd0:    pc_sel = pc_plus4;
            2'd1:    pc_sel = branch_target;
            2'd2:    pc_sel = jump_target;
            default: pc_sel = pc;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and fetch events (start, data hit, timeout).
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        hit       = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (if_en) begin
                    state_nxt = REQ;
                    start     = 1'b1;
                end
            end
            REQ: begin
                if (imem.ready) begin
                    hit       = 1'b1;
                    state_nxt = DONE;
                end else if (cnt == TMO_LAST) begin
                    tmo       = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Instruction latch, wait counter and sticky status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            overrun     <= 1'b0;
            cnt         <= 8'd0;
        end else begin
            if (start) begin
                instr_valid <= 1'b0;
                cnt         <= 8'd0;
            end
            if (in_req && !imem.ready) cnt <= cnt + 8'd1;
            if (hit) begin
                instr       <= imem.rdata;
                instr_valid <= 1'b1;
            end
            if (tmo) begin
                instr       <= NOP_INSTR;
                instr_valid <= 1'b1;
                fetch_err   <= 1'b1;
            end
            if (in_req && if_en) overrun <= 1'b1;
        end
    end

    // PC commit: direct outside REQ, deferred through pending while a fetch
    // is in flight so imem_addr stays stable; a fresh wb_en beats pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            pending_vld <= 1'b0;
        end else if (in_req) begin
            if (wb_en) pending_vld <= 1'b1;
        end else if (wb_en) begin
            pc          <= pc_sel;
            pending_vld <= 1'b0;
        end else if (pending_vld) begin
            pc          <= pending;
            pending_vld <= 1'b0;
        end
    end

    // Pending PC value; qualified by pending_vld so it needs no reset.
    always_ff @(posedge clk) begin
        if (in_req && wb_en) pending <= pc_sel;
    end

endmodule
